// File: rtl/prescaled_counter.sv
// Prescaled up/down counter with saturate-or-wrap range handling and registered step/wrap pulses.
// Define COUNTER_CMP_EN to add the match_val compare input and the registered match pulse.
module prescaled_counter #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned PRE_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [PRE_W-1:0] prescale_lim,
   input  logic             up_dn,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_CMP_EN
   input  logic [WIDTH-1:0] match_val,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             wrap
`ifdef COUNTER_CMP_EN
   ,
   output logic             match
`endif
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [PRE_W-1:0] pre;
   logic [PRE_W-1:0] pre_n;
   logic [WIDTH-1:0] count_n;
   logic [WIDTH-1:0] stepped;
   logic             tick_n;
   logic             wrap_n;
   logic             terminal;
   logic             at_end;
   logic             hold_end;
   logic             changed;

   // Next-state: load beats everything; ">=" lets a lowered limit terminate immediately.
   always_comb begin
      pre_n    = pre;
      count_n  = count;
      tick_n   = 1'b0;
      wrap_n   = 1'b0;
      changed  = 1'b0;
      terminal = en && (pre >= prescale_lim);
      at_end   = up_dn ? (count == ALL_ONES) : (count == '0);
      hold_end = at_end && sat;
      stepped  = up_dn ? (count + WIDTH'(1)) : (count - WIDTH'(1));
      if (load) begin
         count_n = load_val;
         pre_n   = '0;
         changed = 1'b1;
      end else if (terminal) begin
         pre_n  = '0;
         tick_n = 1'b1;
         if (!hold_end) begin
            count_n = stepped;
            wrap_n  = at_end;
            changed = 1'b1;
         end
      end else if (en) begin
         pre_n = pre + PRE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre   <= '0;
         count <= '0;
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         pre   <= pre_n;
         count <= count_n;
         tick  <= tick_n;
         wrap  <= wrap_n;
      end
   end

`ifdef COUNTER_CMP_EN
   logic match_n;

   // Only edges that actually write a new value may pulse; held counts stay quiet.
   always_comb begin
      match_n = changed && (count_n == match_val);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match <= 1'b0;
      end else begin
         match <= match_n;
      end
   end
`else
   logic unused_changed;
   always_comb begin
      unused_changed = changed;
   end
`endif

endmodule

// File: tb/tb_prescaled_counter.sv
// Self-checking bench for prescaled_counter: directed scenarios plus randomized traffic vs. an arithmetic model.
module tb_prescaled_counter;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned PRE_W = 8;
   localparam int MOD  = 256;
   localparam int MAXV = 255;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [PRE_W-1:0] prescale_lim;
   logic             up_dn;
   logic             sat;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tick;
   logic             wrap;
`ifdef COUNTER_CMP_EN
   logic [WIDTH-1:0] match_val;
   logic             match;
`endif

   int errors = 0;
   int checks = 0;

   // Reference state
   int m_pre;
   int m_cnt;
   bit m_tick;
   bit m_wrap;
   bit m_match;

   prescaled_counter #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .prescale_lim (prescale_lim),
      .up_dn        (up_dn),
      .sat          (sat),
      .load         (load),
      .load_val     (load_val),
`ifdef COUNTER_CMP_EN
      .match_val    (match_val),
`endif
      .count        (count),
      .tick         (tick),
      .wrap         (wrap)
`ifdef COUNTER_CMP_EN
      ,
      .match        (match)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pre   = 0;
      m_cnt   = 0;
      m_tick  = 0;
      m_wrap  = 0;
      m_match = 0;
   endtask

   // Behavioural update from the rules: step every lim+1 enabled cycles, range ends saturate or wrap.
   task automatic model_edge();
      int nxt;
      m_tick  = 0;
      m_wrap  = 0;
      m_match = 0;
      if (rst) begin
         model_reset();
      end else if (load) begin
         m_cnt = int'(load_val);
         m_pre = 0;
`ifdef COUNTER_CMP_EN
         m_match = (m_cnt == int'(match_val));
`endif
      end else if (en) begin
         if (m_pre >= int'(prescale_lim)) begin
            m_pre  = 0;
            m_tick = 1;
            nxt = m_cnt + (up_dn ? 1 : -1);
            if (nxt < 0 || nxt > MAXV) begin
               if (!sat) begin
                  m_cnt  = (nxt + MOD) % MOD;
                  m_wrap = 1;
`ifdef COUNTER_CMP_EN
                  m_match = (m_cnt == int'(match_val));
`endif
               end
            end else begin
               m_cnt = nxt;
`ifdef COUNTER_CMP_EN
               m_match = (m_cnt == int'(match_val));
`endif
            end
         end else begin
            m_pre++;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      chk("count", 32'(count), 32'(m_cnt));
      chk("tick", 32'(tick), 32'(m_tick));
      chk("wrap", 32'(wrap), 32'(m_wrap));
`ifdef COUNTER_CMP_EN
      chk("match", 32'(match), 32'(m_match));
`endif
   endtask

   initial begin
      logic [7:0] exp_up[3];
      logic       exp_wr[3];
      logic [7:0] picks[4];
      rst = 1'b1; en = 1'b0; prescale_lim = '0; up_dn = 1'b1; sat = 1'b0;
      load = 1'b0; load_val = '0;
`ifdef COUNTER_CMP_EN
      match_val = 8'd5;
`endif
      model_reset();
      #1;
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_tick", 32'(tick), 32'd0);
      chk("reset_wrap", 32'(wrap), 32'd0);
      cycle();
      cycle();

      // Period-4 count after reset
      prescale_lim = 8'd3; en = 1'b1; rst = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         cycle();
         chk("p4_tick", 32'(tick), (i % 4 == 0) ? 32'd1 : 32'd0);
         if (i % 4 == 0) chk("p4_count", 32'(count), 32'(i / 4));
      end

      // Wrap at top
      prescale_lim = 8'd0; load = 1'b1; load_val = 8'hFE;
      cycle();
      chk("load_fe", 32'(count), 32'hFE);
      chk("load_tick", 32'(tick), 32'd0);
      load = 1'b0;
      exp_up = '{8'hFF, 8'h00, 8'h01};
      exp_wr = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("wrap_up_count", 32'(count), 32'(exp_up[i]));
         chk("wrap_up_flag", 32'(wrap), 32'(exp_wr[i]));
      end

      // Saturate at top
      sat = 1'b1; load = 1'b1; load_val = 8'hFE;
      cycle();
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("sat_count", 32'(count), 32'hFF);
         chk("sat_tick", 32'(tick), 32'd1);
         chk("sat_wrap", 32'(wrap), 32'd0);
      end

      // Down wrap then freeze
      sat = 1'b0; up_dn = 1'b0; load = 1'b1; load_val = 8'h01;
      cycle();
      load = 1'b0;
      cycle();
      chk("down_zero", 32'(count), 32'h00);
      cycle();
      chk("down_ff", 32'(count), 32'hFF);
      chk("down_wrap", 32'(wrap), 32'd1);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("freeze_count", 32'(count), 32'hFF);
         chk("freeze_tick", 32'(tick), 32'd0);
      end

      // Lowered limit while partway through a long prescale
      rst = 1'b1;
      cycle();
      rst = 1'b0; up_dn = 1'b1; en = 1'b1; prescale_lim = 8'd100;
      for (int i = 0; i < 50; i++) cycle();
      chk("long_no_step", 32'(count), 32'd0);
      prescale_lim = 8'd2;
      cycle();
      chk("lower_tick", 32'(tick), 32'd1);
      chk("lower_count", 32'(count), 32'd1);
      for (int i = 1; i <= 6; i++) begin
         cycle();
         chk("p3_tick", 32'(tick), (i % 3 == 0) ? 32'd1 : 32'd0);
      end

      // Asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      chk("async_count", 32'(count), 32'd0);
      chk("async_tick", 32'(tick), 32'd0);
      model_reset();
      cycle();
      rst = 1'b0;

`ifdef COUNTER_CMP_EN
      // Single match pulse while counting up through match_val
      prescale_lim = 8'd0; match_val = 8'd5; up_dn = 1'b1; sat = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         cycle();
         chk("match_pulse", 32'(match), (i == 5) ? 32'd1 : 32'd0);
      end
      #2;
      rst = 1'b1;
      #1;
      chk("match_async_count", 32'(count), 32'd0);
      model_reset();
      cycle();
      rst = 1'b0;
`endif

      // Randomized traffic against the model
      picks = '{8'h00, 8'h01, 8'hFE, 8'hFF};
      for (int i = 0; i < 600; i++) begin
         if (i % 25 == 0) prescale_lim = PRE_W'($urandom_range(0, 4));
         en    = ($urandom_range(0, 7) != 0);
         up_dn = $urandom_range(0, 1) == 1;
         sat   = $urandom_range(0, 1) == 1;
         load  = ($urandom_range(0, 15) == 0);
         load_val = ($urandom_range(0, 1) == 1) ? picks[$urandom_range(0, 3)] : 8'($urandom);
`ifdef COUNTER_CMP_EN
         if (i % 50 == 0) match_val = picks[$urandom_range(0, 3)];
`endif
         rst = ($urandom_range(0, 99) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
